mem_arbiter_nch: RTL and testbench

//  Shares the single unified memory bus among NUM_CH requestors (ch0 = dcache, ch1 = icache, extra = prefetch/MSHR).

---
 rtl/mem_arbiter_nch_pkg.sv | 31 +++
 rtl/mem_arbiter_nch_rr_arbiter.sv | 37 +++
 rtl/mem_arbiter_nch.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_arbiter_nch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_nch_pkg.sv
// Shared types for the N-channel memory bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Bus command encoding mirrors the core's sys_defs values so the arbiter can
// sit directly between the caches and the memory model.
package mem_arbiter_nch_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } BUS_COMMAND;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } ARB_MODE;

    typedef logic [3:0] MEM_TAG;

    // Owner channel field is sized for up to 16 requestors.
    localparam int OWNER_CH_W = 4;

    typedef struct packed {
        logic                  valid;
        logic                  discard;
        logic [OWNER_CH_W-1:0] ch;
    } TAG_OWNER;

endpackage

// File: rtl/mem_arbiter_nch_rr_arbiter.sv
// Rotating-priority arbiter: picks the first set request at or after ptr_i.
// Latency: purely combinational.
// Backpressure: none; grant is one-hot over req_i, all-zero when req_i is empty.
//
// Ports:
//   req_i  [N]   request vector
//   ptr_i  [PW]  index with highest priority (must be < N)
//   gnt_o  [N]   one-hot grant
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic [N-1:0] rot;
    logic [N-1:0] first;
    logic         found;

    // Rotate requests so ptr_i lands on bit 0, take the lowest set bit,
    // then rotate the one-hot result back into channel positions.
    always_comb begin
        rot   = N'({req_i, req_i} >> ptr_i);
        first = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        gnt_o = N'(({first, first} << ptr_i) >> N);
    end

endmodule

// File: rtl/mem_arbiter_nch.sv
// Shares one memory bus among NUM_CH requestors with fixed/RR arbitration,
// starvation guard, per-tag response routing and per-channel load flush.
// Latency: grant and mem_* are combinational; table/pointer/counters update at posedge.
// Backpressure: memory rejects by returning response 0; requestor must hold its command.
//
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   arb_mode_i                  0 = fixed priority, 1 = round-robin
//   req_command/addr/data_i     per-channel request
//   flush_ch_i                  per-channel discard of in-flight loads
//   mem_command/addr/data_o     to memory, from granted channel
//   mem2proc_response/data/tag_i  memory acceptance tag and returning data/tag
//   ch_response_o, ch_tag_o     per-channel acceptance tag and return tag
//   ch_data_o                   returning data broadcast
//   outstanding_o               number of live load-table entries
//   orphan_err_o                sticky: a return tag had no owner
module mem_arbiter_nch
    import mem_arbiter_nch_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          arb_mode_i,
    input  logic [NUM_CH-1:0][1:0]        req_command_i,
    input  logic [NUM_CH-1:0][XLEN-1:0]   req_addr_i,
    input  logic [NUM_CH-1:0][63:0]       req_data_i,
    input  logic [NUM_CH-1:0]             flush_ch_i,
    output logic [1:0]                    mem_command_o,
    output logic [XLEN-1:0]               mem_addr_o,
    output logic [63:0]                   mem_data_o,
    input  logic [3:0]                    mem2proc_response_i,
    input  logic [63:0]                   mem2proc_data_i,
    input  logic [3:0]                    mem2proc_tag_i,
    output logic [NUM_CH-1:0][3:0]        ch_response_o,
    output logic [NUM_CH-1:0][3:0]        ch_tag_o,
    output logic [63:0]                   ch_data_o,
    output logic [$clog2(NUM_TAGS):0]     outstanding_o,
    output logic                          orphan_err_o
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int OUT_W = $clog2(NUM_TAGS) + 1;

    logic [NUM_CH-1:0] req_vld;
    logic [NUM_CH-1:0] starve_hit;
    logic [NUM_CH-1:0] gnt_fix;
    logic [NUM_CH-1:0] gnt_stv;
    logic [NUM_CH-1:0] gnt_rr;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic [1:0]        gnt_cmd;
    logic              accepted;

    logic [CNT_W-1:0]  starve_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  starve_cnt_d [NUM_CH];
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   rr_ptr_d;
    TAG_OWNER          owner_q [NUM_TAGS];
    TAG_OWNER          owner_d [NUM_TAGS];
    logic              orphan_err_q;
    logic              orphan_err_d;

    MEM_TAG            ret_tag;
    MEM_TAG            acc_tag;
    TAG_OWNER          ret_ent;
    logic              ret_vld;
    logic              ret_route;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            req_vld[c]    = (req_command_i[c] != BUS_NONE);
            starve_hit[c] = req_vld[c] && (starve_cnt_q[c] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Fixed priority is a rotating search anchored at channel 0; the
    // starvation sub-arbiter uses the same rule over starved channels only.
    rr_arbiter #(.N(NUM_CH), .PW(CH_W)) u_arb_fix (
        .req_i (req_vld),
        .ptr_i ('0),
        .gnt_o (gnt_fix)
    );

    rr_arbiter #(.N(NUM_CH), .PW(CH_W)) u_arb_stv (
        .req_i (starve_hit),
        .ptr_i ('0),
        .gnt_o (gnt_stv)
    );

    rr_arbiter #(.N(NUM_CH), .PW(CH_W)) u_arb_rr (
        .req_i (req_vld),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_rr)
    );

    // ------------------------------------------------------------------
    // Grant select and bus mux
    // ------------------------------------------------------------------
    always_comb begin
        if (arb_mode_i == ARB_RR) begin
            gnt = gnt_rr;
        end else if (|starve_hit) begin
            gnt = gnt_stv;
        end else begin
            gnt = gnt_fix;
        end

        gnt_idx    = '0;
        gnt_cmd    = BUS_NONE;
        mem_addr_o = '0;
        mem_data_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                gnt_idx    = CH_W'(c);
                gnt_cmd    = req_command_i[c];
                mem_addr_o = req_addr_i[c];
                mem_data_o = req_data_i[c];
            end
        end
        mem_command_o = gnt_cmd;

        acc_tag  = mem2proc_response_i;
        accepted = (|gnt) && (acc_tag != '0);

        for (int c = 0; c < NUM_CH; c++) begin
            ch_response_o[c] = gnt[c] ? mem2proc_response_i : 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counters and round-robin pointer
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_vld[c] && !(accepted && gnt[c])) begin
                starve_cnt_d[c] = (starve_cnt_q[c] == CNT_W'(STARVE_LIMIT))
                                ? starve_cnt_q[c]
                                : starve_cnt_q[c] + CNT_W'(1);
            end else begin
                starve_cnt_d[c] = '0;
            end
        end

        // Pointer only advances on acceptance so a rejected channel retries first.
        rr_ptr_d = rr_ptr_q;
        if (accepted && (arb_mode_i == ARB_RR)) begin
            rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Return routing and tag owner table
    // ------------------------------------------------------------------
    always_comb begin
        ret_tag   = mem2proc_tag_i;
        ret_ent   = owner_q[ret_tag];
        ret_vld   = (ret_tag != '0);
        ret_route = ret_vld && ret_ent.valid && !ret_ent.discard;

        for (int c = 0; c < NUM_CH; c++) begin
            ch_tag_o[c] = (ret_route && (ret_ent.ch == OWNER_CH_W'(c))) ? ret_tag : 4'd0;
        end
        ch_data_o = mem2proc_data_i;

        orphan_err_d = orphan_err_q | (ret_vld && !ret_ent.valid);

        // Order matters: flush marks, then the return clears its entry,
        // then a new acceptance of the same tag overwrites it.
        for (int t = 0; t < NUM_TAGS; t++) begin
            owner_d[t] = owner_q[t];
            for (int c = 0; c < NUM_CH; c++) begin
                if (owner_q[t].valid && flush_ch_i[c] &&
                    (owner_q[t].ch == OWNER_CH_W'(c))) begin
                    owner_d[t].discard = 1'b1;
                end
            end
        end

        if (ret_vld) begin
            owner_d[ret_tag] = '0;
        end

        if (accepted && (gnt_cmd == BUS_LOAD)) begin
            owner_d[acc_tag] = '{valid:   1'b1,
                                 discard: |(flush_ch_i & gnt),
                                 ch:      OWNER_CH_W'(gnt_idx)};
        end

        outstanding_o = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            outstanding_o = outstanding_o + OUT_W'(owner_q[t].valid);
        end

        orphan_err_o = orphan_err_q;
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                owner_q[t] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                starve_cnt_q[c] <= '0;
            end
            rr_ptr_q     <= '0;
            orphan_err_q <= 1'b0;
        end else begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                owner_q[t] <= owner_d[t];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                starve_cnt_q[c] <= starve_cnt_d[c];
            end
            rr_ptr_q     <= rr_ptr_d;
            orphan_err_q <= orphan_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
module tb_mem_arbiter_nch;

    logic              clk;
    logic              reset;
    logic              arb_mode;
    logic [1:0][1:0]   req_command;
    logic [1:0][31:0]  req_addr;
    logic [1:0][63:0]  req_data;
    logic [1:0]        flush_ch;
    logic [1:0]        mem_command;
    logic [31:0]       mem_addr;
    logic [63:0]       mem_data;
    logic [3:0]        mem2proc_response;
    logic [63:0]       mem2proc_data;
    logic [3:0]        mem2proc_tag;
    logic [1:0][3:0]   ch_response;
    logic [1:0][3:0]   ch_tag;
    logic [63:0]       ch_data;
    logic [4:0]        outstanding;
    logic              orphan_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter_nch #(
        .NUM_CH(2), .NUM_TAGS(16), .STARVE_LIMIT(8), .XLEN(32)
    ) dut (
        .clock_i             (clk),
        .reset_i             (reset),
        .arb_mode_i          (arb_mode),
        .req_command_i       (req_command),
        .req_addr_i          (req_addr),
        .req_data_i          (req_data),
        .flush_ch_i          (flush_ch),
        .mem_command_o       (mem_command),
        .mem_addr_o          (mem_addr),
        .mem_data_o          (mem_data),
        .mem2proc_response_i (mem2proc_response),
        .mem2proc_data_i     (mem2proc_data),
        .mem2proc_tag_i      (mem2proc_tag),
        .ch_response_o       (ch_response),
        .ch_tag_o            (ch_tag),
        .ch_data_o           (ch_data),
        .outstanding_o       (outstanding),
        .orphan_err_o        (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        req_command       = '0;
        req_addr[0]       = 32'h0000_0100;
        req_addr[1]       = 32'h0000_0200;
        req_data          = '0;
        flush_ch          = '0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;
    endtask

    // Advance one clock; inputs change 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_rsp [7];
    int         rr_exp [7];

    initial begin
        set_idle();
        arb_mode = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #2;
        chk("rst_cmd",  64'(mem_command), 64'd0);
        chk("rst_rsp",  64'(ch_response), 64'd0);
        chk("rst_tag",  64'(ch_tag),      64'd0);
        chk("rst_out",  64'(outstanding), 64'd0);
        chk("rst_orph", 64'(orphan_err),  64'd0);

        // Fixed mode: both load, ch0 wins.
        req_command[0]    = 2'd1;
        req_command[1]    = 2'd1;
        mem2proc_response = 4'd3;
        #2;
        chk("t1_cmd",  64'(mem_command),    64'd1);
        chk("t1_addr", 64'(mem_addr),       64'h100);
        chk("t1_rsp0", 64'(ch_response[0]), 64'd3);
        chk("t1_rsp1", 64'(ch_response[1]), 64'd0);
        tick();
        set_idle();
        #2;
        chk("t1_out1", 64'(outstanding), 64'd1);
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEAD_BEEF_0000_0003;
        #2;
        chk("t1_tag0", 64'(ch_tag[0]), 64'd3);
        chk("t1_tag1", 64'(ch_tag[1]), 64'd0);
        chk("t1_data", ch_data,        64'hDEAD_BEEF_0000_0003);
        tick();
        set_idle();
        #2;
        chk("t1_out0", 64'(outstanding), 64'd0);
        chk("t1_orph", 64'(orphan_err),  64'd0);

        // Store acceptance with a concurrent return of tag 4 for ch1.
        req_command[1]    = 2'd1;
        mem2proc_response = 4'd4;
        #2;
        chk("t6_rsp1", 64'(ch_response[1]), 64'd4);
        chk("t6_rsp0", 64'(ch_response[0]), 64'd0);
        tick();
        set_idle();
        req_command[0]    = 2'd2;
        req_data[0]       = 64'h5555_AAAA_1234_5678;
        mem2proc_response = 4'd2;
        mem2proc_tag      = 4'd4;
        #2;
        chk("t6_cmd",  64'(mem_command),    64'd2);
        chk("t6_wdat", mem_data,            64'h5555_AAAA_1234_5678);
        chk("t6_rsp0", 64'(ch_response[0]), 64'd2);
        chk("t6_tag1", 64'(ch_tag[1]),      64'd4);
        chk("t6_tag0", 64'(ch_tag[0]),      64'd0);
        tick();
        set_idle();
        #2;
        chk("t6_out", 64'(outstanding), 64'd0);

        // Flush: ch1 owns 5 and 6, ch0 owns 7.
        req_command[1] = 2'd1; mem2proc_response = 4'd5; tick(); set_idle();
        req_command[1] = 2'd1; mem2proc_response = 4'd6; tick(); set_idle();
        req_command[0] = 2'd1; mem2proc_response = 4'd7; tick(); set_idle();
        #2;
        chk("t4_out3", 64'(outstanding), 64'd3);
        flush_ch = 2'b10;
        tick();
        set_idle();
        #2;
        chk("t4_outf", 64'(outstanding), 64'd3);
        mem2proc_tag = 4'd5;
        #2;
        chk("t4_tag5", 64'(ch_tag), 64'd0);
        tick();
        mem2proc_tag = 4'd6;
        #2;
        chk("t4_tag6", 64'(ch_tag), 64'd0);
        tick();
        mem2proc_tag = 4'd7;
        #2;
        chk("t4_tag7", 64'(ch_tag[0]), 64'd7);
        tick();
        set_idle();
        #2;
        chk("t4_out0", 64'(outstanding), 64'd0);
        chk("t4_orph", 64'(orphan_err),  64'd0);

        // Load accepted in the same cycle as its channel's flush is discarded.
        req_command[1]    = 2'd1;
        mem2proc_response = 4'd8;
        flush_ch          = 2'b10;
        tick();
        set_idle();
        mem2proc_tag = 4'd8;
        #2;
        chk("fa_tag8", 64'(ch_tag), 64'd0);
        tick();
        set_idle();
        #2;
        chk("fa_out",  64'(outstanding), 64'd0);
        chk("fa_orph", 64'(orphan_err),  64'd0);

        // Same tag returns and is re-accepted for another channel.
        req_command[0]    = 2'd1;
        mem2proc_response = 4'd10;
        tick();
        set_idle();
        mem2proc_tag      = 4'd10;
        req_command[1]    = 2'd1;
        mem2proc_response = 4'd10;
        #2;
        chk("st_tag0", 64'(ch_tag[0]), 64'd10);
        chk("st_tag1", 64'(ch_tag[1]), 64'd0);
        tick();
        set_idle();
        #2;
        chk("st_out1", 64'(outstanding), 64'd1);
        mem2proc_tag = 4'd10;
        #2;
        chk("st_tag1b", 64'(ch_tag[1]), 64'd10);
        chk("st_tag0b", 64'(ch_tag[0]), 64'd0);
        tick();
        set_idle();
        #2;
        chk("st_out0", 64'(outstanding), 64'd0);

        // Orphan return.
        mem2proc_tag = 4'd9;
        #2;
        chk("or_tag",  64'(ch_tag),     64'd0);
        chk("or_pre",  64'(orphan_err), 64'd0);
        tick();
        set_idle();
        #2;
        chk("or_set",  64'(orphan_err), 64'd1);
        tick();
        #2;
        chk("or_stky", 64'(orphan_err), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("or_rst",  64'(orphan_err), 64'd0);

        // Round-robin: accepted grants alternate, rejected grants repeat.
        rr_rsp = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1};
        rr_exp = '{0, 1, 0, 1, 1, 1, 0};
        arb_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_idle();
            req_command[0]    = 2'd1;
            req_command[1]    = 2'd1;
            mem2proc_response = rr_rsp[i];
            #2;
            chk($sformatf("rr_%0d", i), 64'(mem_addr),
                (rr_exp[i] == 1) ? 64'h200 : 64'h100);
            tick();
        end
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Starvation guard in fixed mode: ch1 wins on cycles 9 and 18.
        arb_mode = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_idle();
            req_command[0]    = 2'd1;
            req_command[1]    = 2'd1;
            mem2proc_response = 4'd1;
            #2;
            chk($sformatf("sv_%0d", i), 64'(mem_addr),
                (i == 8 || i == 17) ? 64'h200 : 64'h100);
            tick();
        end
        set_idle();
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
